wf68k30l_dr_writeback_buffer: RTL and testbench
===============================================

# wf68k30l_dr_writeback_buffer

Small in-order writeback queue between the execution stage and `WF68K30L_DATA_REGISTERS`. It accepts completed data-register results (single or pair destination), buffers up to `DEPTH` entries, and drains one entry per enabled cycle into the register file's `DR_WR_1`/`DR_WR_2` ports. It pulses `UNMARK` when the last outstanding result has been written, which releases the register file's hazard tracker. `PENDING_HIT` lets decode detect reads of registers that are still queued.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESETn`  in  1  synchronous, active-low reset.
- `WB_VALID`  in  1  execution result available.
- `WB_READY`  out  1  buffer can accept; equals `!full`, derived from the registered count.
- `WB_DATA_1`, `WB_DATA_2`  in  32  result for the primary and secondary destination.
- `WB_SEL_1`, `WB_SEL_2`  in  3  destination Dn numbers.
- `WB_PAIR`  in  1  secondary destination also written (DIVx.L/MULx.L pair).
- `WB_SIZE`  in  2  operand size, passed through to `OP_SIZE`.
- `DRAIN_EN`  in  1  register-file write slot available this cycle.
- `FLUSH`  in  1  exception/pipeline flush; discard all entries.
- `RD_SEL_1`, `RD_SEL_2`  in  3  decode read selects for `PENDING_HIT`.
- `DR_IN_1`, `DR_IN_2`  out  32  head data.
- `DR_SEL_WR_1`, `DR_SEL_WR_2`  out  3  head destinations.
- `DR_WR_1`, `DR_WR_2`  out  1  write strobes.
- `OP_SIZE`  out  2  head size.
- `UNMARK`  out  1  one-cycle pulse meaning the queue has drained or been flushed.
- `PENDING_HIT`  out  1  a read select matches a valid queued destination.

## Operation
- Circular FIFO with read/write pointers of `$clog2(DEPTH)` bits (natural wrap) and a count of `$clog2(DEPTH)+1` bits; `full` = (count == DEPTH), `empty` = (count == 0).
- Push happens when `WB_VALID && WB_READY && !FLUSH`. The entry stores data_1, data_2, sel_1, sel_2, pair and size.
- Pop happens when `!empty && DRAIN_EN && !FLUSH`.
  - `DR_WR_1` = pop.
  - `DR_WR_2` = pop && head.pair.
  - `DR_IN_*`, `DR_SEL_WR_*` and `OP_SIZE` show the head entry whenever the queue is non-empty, and are 0 when it is empty.
- Push and pop in the same cycle leave the count unchanged. When full, push is blocked even if a pop occurs that cycle; there is no combinational ready path.
- `FLUSH` has priority over everything:
  - next state: pointers = 0, count = 0;
  - the same cycle: no write strobes, and the push is dropped.
- `UNMARK` is a registered pulse. It is set to 1 at the edge where either:
  - a pop took count from 1 to 0 with no simultaneous push, or
  - `FLUSH` was high.
  
  Otherwise it is 0. A flush of an already-empty queue still pulses.
- `PENDING_HIT` (combinational) is high if, for any valid entry, `RD_SEL_1` or `RD_SEL_2` equals sel_1, or equals sel_2 when that entry's pair bit is set.
  - The entry popped this cycle still counts as pending.
  - An entry being pushed this cycle does not count yet.
- Same destination written on both ports of one entry: `DR_WR_1` and `DR_WR_2` both assert. The register file resolves the conflict; this block does not check it.

## Timing
- Reset (`RESETn` = 0 at an edge): count = 0, pointers = 0, `UNMARK` = 0.
  - All outputs read 0 after that edge: `WB_READY` = 1 once count = 0.
  - Reset during a drain discards every entry and does not pulse `UNMARK`.
- Latency: an entry pushed at edge N is at the head and can be written at the cycle after edge N when the queue was empty. There is no push-to-write bypass.
- Throughput: one entry per cycle, sustained with `DRAIN_EN` held high.
- `UNMARK` appears in the cycle after the final write strobe.
- `DRAIN_EN` low holds the head stable; there is no timeout.

## Structure
- Shared package `wf68k30l_pkg` holds:
  - the `wb_entry_t` struct (data_1, data_2, sel_1, sel_2, pair, size);
  - the `op_size_t` encoding;
  - the `DR_SEL_W` = 3 constant.
- One natural sub-module, `wf68k30l_sync_fifo`: a parametric storage/pointer/count FIFO with a flush port. The top level adds the pop gating, the `UNMARK` logic and the `PENDING_HIT` compare.

## Test plan
- Reset, then push one entry (sel_1 = 3, data 0x12345678, pair = 0) with `DRAIN_EN` = 1:
  - next cycle: `DR_WR_1` = 1, `DR_SEL_WR_1` = 3, `DR_IN_1` = 0x12345678, `DR_WR_2` = 0;
  - the cycle after: `UNMARK` = 1 for exactly one cycle.
- Hold `DRAIN_EN` = 0 and push 4 entries:
  - `WB_READY` = 0 after the 4th push;
  - a 5th `WB_VALID` is not accepted;
  - releasing `DRAIN_EN` gives 4 writes in order over 4 cycles, then one `UNMARK`.
- Pair entry (sel_1 = 2, sel_2 = 5, pair = 1): a single cycle has `DR_WR_1` = `DR_WR_2` = 1 with `DR_SEL_WR_2` = 5.
- Queue 2 entries with `DRAIN_EN` = 0, then assert `FLUSH`:
  - no write strobes in that cycle;
  - count = 0 next cycle;
  - `UNMARK` pulses once.
- Queue an entry with sel_2 = 6, pair = 1, and drive `RD_SEL_2` = 6: `PENDING_HIT` = 1. After the pop, `PENDING_HIT` = 0.
- Keep one entry queued while pushing and popping every cycle for 10 cycles: count stays at 1 and `UNMARK` never pulses. Pull `RESETn` low mid-stream: all outputs are 0 and no `UNMARK` pulses.

Source files
------------

// File: rtl/wf68k30l_pkg.sv
// Shared types for the WF68K30L data-register writeback path.
// Holds the queued writeback entry layout and the operand size encoding.
package wf68k30l_pkg;

    localparam int DR_SEL_W = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_RSVD = 2'd3
    } op_size_t;

    typedef struct packed {
        logic [31:0]         data_1;
        logic [31:0]         data_2;
        logic [DR_SEL_W-1:0] sel_1;
        logic [DR_SEL_W-1:0] sel_2;
        logic                pair;
        op_size_t            size;
    } wb_entry_t;

endpackage

// File: rtl/wf68k30l_sync_fifo.sv
// Parametric circular FIFO with pointer/count bookkeeping and a flush port.
// Storage is exposed so the owner can search queued entries.
module wf68k30l_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  T                           i_wdata,
    output T                           o_head,
    output T                           o_entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked purely by the count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/wf68k30l_dr_writeback_buffer.sv
// In-order writeback queue feeding the data register file write ports.
// Pulses UNMARK when the queue empties and flags reads of queued registers.
module wf68k30l_dr_writeback_buffer
    import wf68k30l_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                WB_VALID,
    output logic                WB_READY,
    input  logic [31:0]         WB_DATA_1,
    input  logic [31:0]         WB_DATA_2,
    input  logic [DR_SEL_W-1:0] WB_SEL_1,
    input  logic [DR_SEL_W-1:0] WB_SEL_2,
    input  logic                WB_PAIR,
    input  logic [1:0]          WB_SIZE,
    input  logic                DRAIN_EN,
    input  logic                FLUSH,
    input  logic [DR_SEL_W-1:0] RD_SEL_1,
    input  logic [DR_SEL_W-1:0] RD_SEL_2,
    output logic [31:0]         DR_IN_1,
    output logic [31:0]         DR_IN_2,
    output logic [DR_SEL_W-1:0] DR_SEL_WR_1,
    output logic [DR_SEL_W-1:0] DR_SEL_WR_2,
    output logic                DR_WR_1,
    output logic                DR_WR_2,
    output logic [1:0]          OP_SIZE,
    output logic                UNMARK,
    output logic                PENDING_HIT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t      w_wdata;
    wb_entry_t      w_head;
    wb_entry_t      w_entries [DEPTH];
    logic [AW-1:0]  w_rd_ptr;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_hit;
    logic           r_unmark;

    assign w_wdata = '{
        data_1: WB_DATA_1,
        data_2: WB_DATA_2,
        sel_1:  WB_SEL_1,
        sel_2:  WB_SEL_2,
        pair:   WB_PAIR,
        size:   op_size_t'(WB_SIZE)
    };

    // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
    assign WB_READY = !w_full;
    assign w_push   = WB_VALID && !w_full && !FLUSH;
    assign w_pop    = !w_empty && DRAIN_EN && !FLUSH;

    wf68k30l_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_entry_t)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RESETn),
        .i_flush   (FLUSH),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wdata   (w_wdata),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_rd_ptr  (w_rd_ptr),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign DR_WR_1     = w_pop;
    assign DR_WR_2     = w_pop && w_head.pair;
    assign DR_IN_1     = w_empty ? '0 : w_head.data_1;
    assign DR_IN_2     = w_empty ? '0 : w_head.data_2;
    assign DR_SEL_WR_1 = w_empty ? '0 : w_head.sel_1;
    assign DR_SEL_WR_2 = w_empty ? '0 : w_head.sel_2;
    assign OP_SIZE     = w_empty ? '0 : w_head.size;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_unmark <= 1'b0;
        end else begin
            r_unmark <= FLUSH || (w_pop && !w_push && (w_count == CW'(1)));
        end
    end

    assign UNMARK = r_unmark;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [AW-1:0] w_off;
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - w_rd_ptr;
            if ({1'b0, w_off} < w_count) begin
                if ((RD_SEL_1 == w_entries[i].sel_1) || (RD_SEL_2 == w_entries[i].sel_1))
                    w_hit = 1'b1;
                if (w_entries[i].pair &&
                    ((RD_SEL_1 == w_entries[i].sel_2) || (RD_SEL_2 == w_entries[i].sel_2)))
                    w_hit = 1'b1;
            end
        end
    end

    assign PENDING_HIT = w_hit;

endmodule

// File: tb/tb_wf68k30l_dr_writeback_buffer.sv
// Directed bench for the writeback buffer: single, full, pair, flush,
// pending-hit, sustained streaming and mid-stream reset scenarios.
module tb_wf68k30l_dr_writeback_buffer;

    logic        CLK;
    logic        RESETn;
    logic        WB_VALID;
    logic        WB_READY;
    logic [31:0] WB_DATA_1;
    logic [31:0] WB_DATA_2;
    logic [2:0]  WB_SEL_1;
    logic [2:0]  WB_SEL_2;
    logic        WB_PAIR;
    logic [1:0]  WB_SIZE;
    logic        DRAIN_EN;
    logic        FLUSH;
    logic [2:0]  RD_SEL_1;
    logic [2:0]  RD_SEL_2;
    logic [31:0] DR_IN_1;
    logic [31:0] DR_IN_2;
    logic [2:0]  DR_SEL_WR_1;
    logic [2:0]  DR_SEL_WR_2;
    logic        DR_WR_1;
    logic        DR_WR_2;
    logic [1:0]  OP_SIZE;
    logic        UNMARK;
    logic        PENDING_HIT;

    int n_assert = 0;
    int n_fail   = 0;

    wf68k30l_dr_writeback_buffer #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .WB_VALID    (WB_VALID),
        .WB_READY    (WB_READY),
        .WB_DATA_1   (WB_DATA_1),
        .WB_DATA_2   (WB_DATA_2),
        .WB_SEL_1    (WB_SEL_1),
        .WB_SEL_2    (WB_SEL_2),
        .WB_PAIR     (WB_PAIR),
        .WB_SIZE     (WB_SIZE),
        .DRAIN_EN    (DRAIN_EN),
        .FLUSH       (FLUSH),
        .RD_SEL_1    (RD_SEL_1),
        .RD_SEL_2    (RD_SEL_2),
        .DR_IN_1     (DR_IN_1),
        .DR_IN_2     (DR_IN_2),
        .DR_SEL_WR_1 (DR_SEL_WR_1),
        .DR_SEL_WR_2 (DR_SEL_WR_2),
        .DR_WR_1     (DR_WR_1),
        .DR_WR_2     (DR_WR_2),
        .OP_SIZE     (OP_SIZE),
        .UNMARK      (UNMARK),
        .PENDING_HIT (PENDING_HIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESETn = 0; WB_VALID = 0; WB_DATA_1 = 0; WB_DATA_2 = 0;
        WB_SEL_1 = 0; WB_SEL_2 = 0; WB_PAIR = 0; WB_SIZE = 0;
        DRAIN_EN = 0; FLUSH = 0; RD_SEL_1 = 7; RD_SEL_2 = 7;
        tick(); tick();
        chk("rst_ready", WB_READY, 1);
        chk("rst_wr1", DR_WR_1, 0);
        chk("rst_unmark", UNMARK, 0);
        chk("rst_in1", DR_IN_1, 0);
        chk("rst_hit", PENDING_HIT, 0);
        RESETn = 1;

        // single entry
        WB_VALID = 1; WB_SEL_1 = 3; WB_DATA_1 = 32'h12345678; WB_PAIR = 0; DRAIN_EN = 1;
        tick();
        WB_VALID = 0; #1;
        chk("s_wr1", DR_WR_1, 1);
        chk("s_sel1", DR_SEL_WR_1, 3);
        chk("s_in1", DR_IN_1, 32'h12345678);
        chk("s_wr2", DR_WR_2, 0);
        chk("s_unmark_early", UNMARK, 0);
        tick();
        chk("s_unmark", UNMARK, 1);
        chk("s_wr1_after", DR_WR_1, 0);
        tick();
        chk("s_unmark_once", UNMARK, 0);

        // fill to full with drain held off
        DRAIN_EN = 0;
        for (int k = 0; k < 4; k++) begin
            WB_VALID = 1; WB_SEL_1 = 3'(k); WB_DATA_1 = 32'hA0 + k;
            tick();
        end
        chk("f_ready", WB_READY, 0);
        WB_SEL_1 = 7; WB_DATA_1 = 32'hFF;
        tick();
        WB_VALID = 0; #1;
        chk("f_hold_wr", DR_WR_1, 0);
        chk("f_hold_head", DR_IN_1, 32'hA0);
        DRAIN_EN = 1; #1;
        for (int k = 0; k < 4; k++) begin
            chk("f_wr1", DR_WR_1, 1);
            chk("f_data", DR_IN_1, 32'hA0 + k);
            chk("f_sel", DR_SEL_WR_1, k);
            chk("f_unmark_mid", UNMARK, 0);
            tick();
        end
        chk("f_unmark", UNMARK, 1);
        chk("f_empty_wr", DR_WR_1, 0);
        chk("f_ready_again", WB_READY, 1);
        tick();
        chk("f_unmark_once", UNMARK, 0);

        // pair entry
        WB_VALID = 1; WB_SEL_1 = 2; WB_SEL_2 = 5; WB_DATA_1 = 32'h11; WB_DATA_2 = 32'h22;
        WB_PAIR = 1; WB_SIZE = 2;
        tick();
        WB_VALID = 0; WB_PAIR = 0; #1;
        chk("p_wr1", DR_WR_1, 1);
        chk("p_wr2", DR_WR_2, 1);
        chk("p_sel2", DR_SEL_WR_2, 5);
        chk("p_in2", DR_IN_2, 32'h22);
        chk("p_size", OP_SIZE, 2);
        tick();
        chk("p_wr2_after", DR_WR_2, 0);
        chk("p_unmark", UNMARK, 1);
        tick();

        // flush with two queued entries and a competing push
        DRAIN_EN = 0; WB_SIZE = 0;
        WB_VALID = 1; WB_SEL_1 = 1; WB_DATA_1 = 32'h100;
        tick();
        WB_SEL_1 = 4; WB_DATA_1 = 32'h400;
        tick();
        WB_SEL_1 = 6; WB_DATA_1 = 32'h66; FLUSH = 1; DRAIN_EN = 1; #1;
        chk("fl_wr1", DR_WR_1, 0);
        chk("fl_wr2", DR_WR_2, 0);
        tick();
        FLUSH = 0; WB_VALID = 0; DRAIN_EN = 0; #1;
        chk("fl_unmark", UNMARK, 1);
        chk("fl_ready", WB_READY, 1);
        chk("fl_empty_in1", DR_IN_1, 0);
        chk("fl_empty_sel", DR_SEL_WR_1, 0);
        tick();
        chk("fl_unmark_once", UNMARK, 0);

        // pending hit on a paired secondary destination
        WB_VALID = 1; WB_SEL_1 = 1; WB_SEL_2 = 6; WB_PAIR = 1; WB_DATA_1 = 32'h5; RD_SEL_2 = 6; #1;
        chk("ph_pushing", PENDING_HIT, 0);
        tick();
        WB_VALID = 0; WB_PAIR = 0; #1;
        chk("ph_queued", PENDING_HIT, 1);
        DRAIN_EN = 1; #1;
        chk("ph_popping", PENDING_HIT, 1);
        chk("ph_pop_wr", DR_WR_1, 1);
        tick();
        chk("ph_after", PENDING_HIT, 0);
        chk("ph_unmark", UNMARK, 1);
        RD_SEL_2 = 7;
        tick();

        // steady stream with one entry in flight
        DRAIN_EN = 0; WB_VALID = 1; WB_SEL_1 = 5; WB_DATA_1 = 32'h500;
        tick();
        DRAIN_EN = 1;
        for (int k = 0; k < 10; k++) begin
            WB_DATA_1 = 32'h600 + k; #1;
            chk("st_wr1", DR_WR_1, 1);
            chk("st_head", DR_IN_1, (k == 0) ? 32'h500 : 32'h600 + k - 1);
            chk("st_unmark", UNMARK, 0);
            chk("st_ready", WB_READY, 1);
            tick();
        end

        // reset mid-stream
        RESETn = 0;
        tick();
        WB_VALID = 0; #1;
        chk("rr_wr1", DR_WR_1, 0);
        chk("rr_in1", DR_IN_1, 0);
        chk("rr_unmark", UNMARK, 0);
        chk("rr_hit", PENDING_HIT, 0);
        chk("rr_ready", WB_READY, 1);
        RESETn = 1;
        tick();
        chk("rr_unmark_after", UNMARK, 0);
        chk("rr_wr1_after", DR_WR_1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
